div_arbiter: RTL and testbench

// Shares the single multi-cycle divider between the two issue pipes (requester 0/1).

---
 rtl/div_arbiter.sv | 162 ++++++++++++++++
 tb/tb_div_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divider between two issue pipes.
// Latches the winner's operands, sequences start/annul, and returns the result with a done pulse.
`timescale 1ns/1ps

module div_arbiter #(
    parameter int unsigned KILL_DRAIN = 2,
    parameter bit          RR_INIT    = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req0_i,
    input  logic        sign0_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] b0_i,
    input  logic        kill0_i,
    output logic        done0_o,
    output logic        stall0_o,

    input  logic        req1_i,
    input  logic        sign1_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] b1_i,
    input  logic        kill1_i,
    output logic        done1_o,
    output logic        stall1_o,

    output logic [63:0] res_o,
    output logic        busy_o,

    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int unsigned CW = (KILL_DRAIN > 2) ? $clog2(KILL_DRAIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;
    logic          r_owner;
    logic          r_killed;
    logic          r_signed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_done;
    logic [1:0]    w_done_nxt;
    logic [63:0]   r_res;
    logic [31:0]   r_op1;
    logic [31:0]   r_op2;

    logic [1:0]    w_req_vld;
    logic          w_grant;
    logic          w_grant_id;
    logic          w_owner_kill;
    logic          w_killed_nxt;
    logic          w_res_load;

    // A requester whose done is pulsing still shows the finished op's request; never re-grant it.
    assign w_req_vld    = {req1_i & ~kill1_i & ~r_done[1],
                           req0_i & ~kill0_i & ~r_done[0]};
    assign w_grant_id   = (&w_req_vld) ? r_prio : w_req_vld[1];
    assign w_owner_kill = r_owner ? kill1_i : kill0_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 2'b00;
        w_killed_nxt = r_killed;
        w_grant      = 1'b0;
        w_res_load   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|w_req_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // Kill wins over a simultaneous ready: the result is dropped and the divider annulled.
                if (w_owner_kill) begin
                    w_state_nxt  = S_DRAIN;
                    w_cnt_nxt    = CW'(KILL_DRAIN - 1);
                    w_killed_nxt = 1'b1;
                end else if (div_ready_i) begin
                    w_state_nxt  = S_DRAIN;
                    w_cnt_nxt    = '0;
                    w_killed_nxt = 1'b0;
                    w_res_load   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt         = S_IDLE;
                    w_done_nxt[r_owner] = ~r_killed;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: every register is cleared by reset; there is no storage array here that could skip it.
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_prio   <= RR_INIT;
            r_owner  <= 1'b0;
            r_killed <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 2'b00;
            r_res    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_killed <= w_killed_nxt;
            if (w_grant) begin
                r_owner  <= w_grant_id;
                r_prio   <= ~w_grant_id;
                r_op1    <= w_grant_id ? a1_i    : a0_i;
                r_op2    <= w_grant_id ? b1_i    : b0_i;
                r_signed <= w_grant_id ? sign1_i : sign0_i;
            end
            if (w_res_load) begin
                r_res <= div_result_i;
            end
        end
    end

    assign busy_o       = (r_state != S_IDLE);
    assign div_start_o  = (r_state == S_BUSY);
    assign div_annul_o  = (r_state == S_DRAIN) & r_killed;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign res_o        = r_res;
    assign done0_o      = r_done[0];
    assign done1_o      = r_done[1];
    assign stall0_o     = req0_i & ~r_done[0];
    assign stall1_o     = req1_i & ~r_done[1];

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider (ready 35 BUSY cycles in, 3 for divisor 0).
`timescale 1ns/1ps

module tb_div_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_i, sign0_i, kill0_i, req1_i, sign1_i, kill1_i;
    logic [31:0] a0_i, b0_i, a1_i, b1_i;
    logic        done0_o, stall0_o, done1_o, stall1_o;
    logic [63:0] res_o;
    logic        busy_o, div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int n_cmp  = 0;
    int n_fail = 0;

    div_arbiter #(.KILL_DRAIN(2), .RR_INIT(1'b0)) dut (
        .clk(clk), .resetn(resetn),
        .req0_i(req0_i), .sign0_i(sign0_i), .a0_i(a0_i), .b0_i(b0_i), .kill0_i(kill0_i),
        .done0_o(done0_o), .stall0_o(stall0_o),
        .req1_i(req1_i), .sign1_i(sign1_i), .a1_i(a1_i), .b1_i(b1_i), .kill1_i(kill1_i),
        .done1_o(done1_o), .stall1_o(stall1_o),
        .res_o(res_o), .busy_o(busy_o),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i)
    );

    always #5 clk = ~clk;

    // Divider model: counts consecutive start cycles; annul or idle restarts it.
    int unsigned div_cnt;
    always @(posedge clk) begin
        if (!resetn || div_annul_o || !div_start_o) div_cnt <= 0;
        else                                        div_cnt <= div_cnt + 1;
    end

    function automatic logic [63:0] div_model(input logic s, input logic [31:0] a, input logic [31:0] b);
        int q, r;
        if (b == 32'd0) return 64'h0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    assign div_ready_i  = div_start_o && (div_cnt == ((div_op2_o == 32'd0) ? 32'd2 : 32'd34));
    assign div_result_i = div_model(div_signed_o, div_op1_o, div_op2_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ctl"}, {58'b0, busy_o, div_start_o, div_annul_o, done0_o, done1_o, div_signed_o}, 64'h0);
        check({tag, " res"}, res_o, 64'h0);
        check({tag, " ops"}, {div_op1_o, div_op2_o}, 64'h0);
    endtask

    task automatic set_req(input logic id, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (id) begin req1_i = 1'b1; sign1_i = s; a1_i = a; b1_i = b; end
        else    begin req0_i = 1'b1; sign0_i = s; a0_i = a; b0_i = b; end
    endtask

    // Waits for the next done pulse; k = negedges waited (-1 on timeout).
    task automatic wait_done(output int k, output logic [1:0] d, output logic [63:0] r);
        k = -1; d = 2'b00; r = '0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (done0_o || done1_o) begin
                k = i; d = {done1_o, done0_o}; r = res_o;
                break;
            end
        end
    endtask

    // Issues one op from an idle arbiter, scrambling the requester's operand inputs while it runs.
    task automatic run_op(input logic id, input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res, output logic other,
                          output logic ops_ok, output logic stall_ok);
        logic own_done, own_stall;
        lat = -1; res = '0; other = 1'b0; ops_ok = 1'b1; stall_ok = 1'b1;
        set_req(id, s, a, b);
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            own_done  = id ? done1_o  : done0_o;
            own_stall = id ? stall1_o : stall0_o;
            if ((id ? done0_o : done1_o) !== 1'b0) other = 1'b1;
            if (div_op1_o !== a || div_op2_o !== b || div_signed_o !== s) ops_ok = 1'b0;
            if (own_done === 1'b1) begin
                lat = k; res = res_o;
                if (own_stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (own_stall !== 1'b1) stall_ok = 1'b0;
            if (id) begin a1_i = ~a; b1_i = b ^ 32'h5; sign1_i = ~s; end
            else    begin a0_i = ~a; b0_i = b ^ 32'h5; sign0_i = ~s; end
        end
        if (id) begin req1_i = 1'b0; a1_i = '0; b1_i = '0; sign1_i = 1'b0; end
        else    begin req0_i = 1'b0; a0_i = '0; b0_i = '0; sign0_i = 1'b0; end
    endtask

    typedef struct {
        string       name;
        logic        id;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          k, lat;
        logic [1:0]  d;
        logic [63:0] r;
        logic        other, ops_ok, stall_ok, saw0;

        vecs[0] = '{"u100/7",   1'b0, 1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 37};
        vecs[1] = '{"s-7/2",    1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 37};
        vecs[2] = '{"u123/0",   1'b0, 1'b0, 32'd123,       32'd0,         64'h00000000_00000000, 5};
        vecs[3] = '{"uFFFF/16", 1'b1, 1'b0, 32'hFFFFFFFF,  32'd16,        64'h0000000F_0FFFFFFF, 37};
        vecs[4] = '{"s100/-7",  1'b0, 1'b1, 32'd100,       32'hFFFFFFF9,  64'h00000002_FFFFFFF2, 37};
        vecs[5] = '{"s5/0",     1'b1, 1'b1, 32'd5,         32'd0,         64'h00000000_00000000, 5};

        resetn = 1'b0;
        {req0_i, sign0_i, kill0_i, req1_i, sign1_i, kill1_i} = '0;
        {a0_i, b0_i, a1_i, b1_i} = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset stall", {62'b0, stall1_o, stall0_o}, 64'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Both request out of reset: req0 first, then req1 re-granted in the done cycle, then req0 again.
        set_req(1'b0, 1'b0, 32'd20, 32'd3);
        set_req(1'b1, 1'b0, 32'd9,  32'd4);
        wait_done(k, d, r);
        check("rr1 who", 64'(d), 64'h1);
        check("rr1 res", r, 64'h00000002_00000006);
        check("rr1 lat", 64'(k), 64'd37);
        a0_i = 32'd30; b0_i = 32'd7;
        wait_done(k, d, r);
        check("rr2 who", 64'(d), 64'h2);
        check("rr2 res", r, 64'h00000001_00000002);
        check("rr2 lat", 64'(k), 64'd37);
        req1_i = 1'b0;
        wait_done(k, d, r);
        check("rr3 who", 64'(d), 64'h1);
        check("rr3 res", r, 64'h00000002_00000004);
        check("rr3 lat", 64'(k), 64'd37);
        req0_i = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].id, vecs[i].sgn, vecs[i].a, vecs[i].b, lat, r, other, ops_ok, stall_ok);
            check({vecs[i].name, " res"},   r, vecs[i].exp_res);
            check({vecs[i].name, " lat"},   64'(lat), 64'(vecs[i].exp_lat));
            check({vecs[i].name, " other"}, 64'(other), 64'h0);
            check({vecs[i].name, " hold"},  64'(ops_ok), 64'h1);
            check({vecs[i].name, " stall"}, 64'(stall_ok), 64'h1);
            @(negedge clk);
            check({vecs[i].name, " pulse"}, {62'b0, done1_o, done0_o}, 64'h0);
        end

        // Kill of the owner at c10 with req1 pending since c1.
        saw0 = 1'b0;
        set_req(1'b0, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'd9, 32'd4);
        repeat (9) begin
            @(negedge clk);
            saw0 |= done0_o;
        end
        kill0_i = 1'b1;
        @(negedge clk);
        saw0 |= done0_o;
        check("kill c11 ctl", {61'b0, busy_o, div_start_o, div_annul_o}, 64'h5);
        check("kill c11 op1", 64'(div_op1_o), 64'd100);
        @(negedge clk);
        saw0 |= done0_o;
        check("kill c12 ctl", {61'b0, busy_o, div_start_o, div_annul_o}, 64'h5);
        @(negedge clk);
        saw0 |= done0_o;
        check("kill c13 ctl", {61'b0, busy_o, div_start_o, div_annul_o}, 64'h0);
        @(negedge clk);
        check("kill c14 ctl", {61'b0, busy_o, div_start_o, div_annul_o}, 64'h6);
        check("kill c14 op1", 64'(div_op1_o), 64'd9);
        req0_i = 1'b0;
        @(negedge clk);
        kill0_i = 1'b0;
        wait_done(k, d, r);
        check("kill who",   64'(d), 64'h2);
        check("kill res",   r, 64'h00000001_00000002);
        check("kill lat",   64'(k), 64'd35);
        check("kill done0", 64'(saw0), 64'h0);
        req1_i = 1'b0;
        @(negedge clk);

        // Reset mid-op at c20, then a clean 50/5.
        set_req(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        req0_i = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        resetn = 1'b1;
        @(negedge clk);
        run_op(1'b0, 1'b0, 32'd50, 32'd5, lat, r, other, ops_ok, stall_ok);
        check("post-rst res", r, 64'h00000000_0000000A);
        check("post-rst lat", 64'(lat), 64'd37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
